// File: rtl/dcache_dm.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and a block-wide memory port.
// Read hits are answered in the request cycle; misses stall the pipeline while a victim is evicted and the line filled.
module dcache_dm #(
    parameter int INDEX_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int NUM_BLOCKS = 1 << INDEX_W;
    localparam int TAG_W      = 28 - INDEX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_BLOCKS-1:0]   valid_q, valid_d;
    logic [NUM_BLOCKS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]        tag_q  [NUM_BLOCKS];
    logic [TAG_W-1:0]        tag_d  [NUM_BLOCKS];
    logic [127:0]            data_q [NUM_BLOCKS];
    logic [127:0]            data_d [NUM_BLOCKS];

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic [1:0]         word_off;
    logic [6:0]         word_lsb;
    logic               req;
    logic               hit;

    assign req_tag   = proc_addr[29:INDEX_W+2];
    assign req_index = proc_addr[INDEX_W+1:2];
    assign word_off  = proc_addr[1:0];
    assign word_lsb  = {word_off, 5'b00000};
    assign req       = proc_read | proc_write;
    assign hit       = valid_q[req_index] && (tag_q[req_index] == req_tag);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d    = state_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        data_d     = data_q;
        proc_rdata = '0;
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit) begin
                        // A simultaneous read and write is served as a write.
                        if (proc_write) begin
                            data_d[req_index][word_lsb +: 32] = proc_wdata;
                            dirty_d[req_index]                = 1'b1;
                        end else begin
                            proc_rdata = data_q[req_index][word_lsb +: 32];
                        end
                    end else begin
                        proc_stall = 1'b1;
                        state_d    = (valid_q[req_index] && dirty_q[req_index]) ? S_WRITEBACK
                                                                                 : S_ALLOCATE;
                    end
                end
            end

            S_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[req_index], req_index};
                mem_wdata  = data_q[req_index];
                if (mem_ready) begin
                    state_d = S_ALLOCATE;
                end
            end

            S_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
                mem_addr   = {req_tag, req_index};
                // The pending store is merged later, when the request hits back in IDLE.
                if (mem_ready) begin
                    data_d[req_index]  = mem_rdata;
                    tag_d[req_index]   = req_tag;
                    valid_d[req_index] = 1'b1;
                    dirty_d[req_index] = 1'b0;
                    state_d            = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // NOTE: tag and data arrays carry no reset; cleared valid bits make their contents unobservable.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: directed accesses push expected responses, monitors pop and compare.
// A small block memory model answers mem requests after a programmable latency.
module tb_dcache_dm;

    logic         clk;
    logic         rst;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    dcache_dm #(.INDEX_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
    } mem_exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]  exp_rd  [$];
    mem_exp_t     exp_mem [$];
    logic [127:0] model   [logic [27:0]];

    int mem_lat   = 4;
    int mem_cnt   = 0;
    bit mon_en    = 1'b0;
    int overlap_n = 0;
    int idle_bad  = 0;
    int rdata_bad = 0;
    int hold_bad  = 0;

    logic        prev_rd;
    logic        prev_wr;
    logic [27:0] prev_addr;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: counts request cycles and pulses mem_ready in the mem_lat-th one.
    always @(negedge clk) begin
        if (mem_ready) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end
        if (rst || !(mem_read || mem_write)) begin
            mem_cnt = 0;
        end else begin
            mem_cnt++;
            if (mem_cnt == mem_lat) begin
                mem_ready = 1'b1;
                if (mem_write) model[mem_addr] = mem_wdata;
                else           mem_rdata = model[mem_addr];
            end
        end
    end

    // Monitor: pops the scoreboard whenever a read completes or a new mem request starts.
    always @(negedge clk) begin
        if (mon_en) begin
            bit       start;
            mem_exp_t e;
            if (proc_read && !proc_write && !proc_stall && !rst) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_read_done", 1, 0);
                end else begin
                    check("rdata", proc_rdata, exp_rd.pop_front());
                end
            end else if (proc_rdata !== 32'h0) begin
                rdata_bad++;
            end

            if (mem_read && mem_write) overlap_n++;
            if (!mem_read && !mem_write && (mem_addr !== 28'h0 || mem_wdata !== 128'h0)) idle_bad++;

            start = (mem_read && !prev_rd) || (mem_write && !prev_wr);
            if (start) begin
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem_req", 1, 0);
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_is_write", mem_write, e.wr);
                    check("mem_addr", mem_addr, e.addr);
                    if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
                end
            end else if ((mem_read || mem_write) && mem_addr !== prev_addr) begin
                hold_bad++;
            end
            prev_rd   = mem_read;
            prev_wr   = mem_write;
            prev_addr = mem_addr;
        end
    end

    task automatic wait_done(output int stalls);
        stalls = 0;
        while (proc_stall === 1'b1 && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [29:0] addr,
                          input logic [31:0] wd, input int exp_stall,
                          input logic [31:0] exp_rdata, input string name);
        int stalls;
        @(posedge clk); #1;
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wd;
        if (rd && !wr) exp_rd.push_back(exp_rdata);
        @(negedge clk);
        wait_done(stalls);
        check({name, "_stall_cycles"}, stalls, exp_stall);
        @(posedge clk); #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        rst        = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        prev_rd    = 1'b0;
        prev_wr    = 1'b0;
        prev_addr  = '0;

        model[28'h4]  = {32'h33, 32'h22, 32'h11, 32'h00};
        model[28'hC]  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        model[28'h9]  = {32'h93, 32'h92, 32'h91, 32'h90};
        model[28'h14] = {32'h143, 32'h142, 32'h141, 32'h140};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_stall", proc_stall, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", proc_rdata, 0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_stall", proc_stall, 0);
            check("idle_mem_req", {mem_read, mem_write}, 0);
        end

        // Clean read miss then hits, writes and a read+write treated as a write.
        mem_lat = 4;
        exp_mem.push_back('{wr: 1'b0, addr: 28'h4, wdata: '0});
        access(1, 0, 30'h10, 32'h0, 5, 32'h00, "clean_miss");
        access(1, 0, 30'h11, 32'h0, 0, 32'h11, "read_hit");
        access(0, 1, 30'h12, 32'hDEADBEEF, 0, 32'h0, "write_hit");
        access(1, 0, 30'h12, 32'h0, 0, 32'hDEADBEEF, "read_after_write");
        access(1, 1, 30'h13, 32'hCAFEF00D, 0, 32'h0, "rd_wr_both");
        access(1, 0, 30'h13, 32'h0, 0, 32'hCAFEF00D, "read_both_word");

        // Dirty eviction: writeback of index 4, then fill of tag 1.
        mem_lat = 3;
        exp_mem.push_back('{wr: 1'b1, addr: 28'h4,
                            wdata: {32'hCAFEF00D, 32'hDEADBEEF, 32'h11, 32'h00}});
        exp_mem.push_back('{wr: 1'b0, addr: 28'hC, wdata: '0});
        access(1, 0, 30'h30, 32'h0, 7, 32'hC0, "dirty_miss");

        // Write miss with single-cycle memory latency.
        mem_lat = 1;
        exp_mem.push_back('{wr: 1'b0, addr: 28'h9, wdata: '0});
        access(0, 1, 30'h25, 32'h12345678, 2, 32'h0, "write_miss");
        access(1, 0, 30'h25, 32'h0, 0, 32'h12345678, "write_miss_merge");
        access(1, 0, 30'h24, 32'h0, 0, 32'h90, "write_miss_neighbor");

        // Refetch of the evicted block returns the written-back word.
        mem_lat = 2;
        exp_mem.push_back('{wr: 1'b0, addr: 28'h4, wdata: '0});
        access(1, 0, 30'h12, 32'h0, 3, 32'hDEADBEEF, "refetch_wb");

        // Reset while ALLOCATE is waiting on memory.
        mem_lat = 40;
        exp_mem.push_back('{wr: 1'b0, addr: 28'h14, wdata: '0});
        @(posedge clk); #1;
        proc_read = 1'b1;
        proc_addr = 30'h50;
        exp_rd.push_back(32'h140);
        @(negedge clk);
        @(negedge clk);
        check("alloc_mem_read", mem_read, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mem_lat = 4;
        exp_mem.push_back('{wr: 1'b0, addr: 28'h14, wdata: '0});
        @(negedge clk);
        check("post_rst_mem_read", mem_read, 0);
        check("post_rst_remiss", proc_stall, 1);
        wait_done(stalls);
        check("post_rst_stall_cycles", stalls, 5);
        @(posedge clk); #1 proc_read = 1'b0;

        // All lines were invalidated, so index 4 tag 0 misses again.
        exp_mem.push_back('{wr: 1'b0, addr: 28'h4, wdata: '0});
        access(1, 0, 30'h11, 32'h0, 5, 32'h11, "post_rst_miss");

        repeat (3) @(negedge clk);
        check("exp_rd_drained", exp_rd.size(), 0);
        check("exp_mem_drained", exp_mem.size(), 0);
        check("no_rd_wr_overlap", overlap_n, 0);
        check("idle_mem_outputs_zero", idle_bad, 0);
        check("rdata_zero_when_idle", rdata_bad, 0);
        check("mem_addr_held", hold_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
